// File: rtl/eth_frame_builder_pkg.sv
// Shared definitions for the Ethernet frame builder: the FSM state set and
// the fixed frame-layout constants.
package eth_frame_builder_pkg;

    typedef enum logic [2:0] {
        ST_FILL = 3'd0,
        ST_DROP = 3'd1,
        ST_PAD  = 3'd2,
        ST_ARM  = 3'd3,
        ST_HOLD = 3'd4
    } state_e;

    localparam logic [7:0] PREAMBLE    = 8'h55;
    localparam logic [7:0] SFD         = 8'hD5;
    localparam int         FRAME_LEN   = 68;
    localparam int         PAYLOAD_LEN = 46;
    localparam int         HDR_LEN     = 14;

endpackage

// File: rtl/eth_payload_ram.sv
// 46 x 8 payload store: one synchronous write port and one registered read
// port. Reads of the location being written return the old contents.
module eth_payload_ram
    import eth_frame_builder_pkg::*;
(
    input  logic       clk,
    input  logic       we_i,
    input  logic [5:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [5:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [0:PAYLOAD_LEN-1];
    logic [7:0] rdata_q;

    // Payload write and registered read; out-of-range read indices yield zero.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (raddr_i < 6'(PAYLOAD_LEN)) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= 8'h00;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_frame_builder.sv
// Ethernet frame builder: collects a payload into RAM, pads short frames to
// 46 bytes, drops excess bytes, then pulses start and locks the image while
// the transmitter reads it out through rd_addr/rd_data.
module eth_frame_builder
    import eth_frame_builder_pkg::*;
#(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          HOLD_CYCLES = 1200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       start,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       overflow
);

    localparam int               CNT_W     = ($clog2(HOLD_CYCLES) < 11) ? 11 : $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [5:0]       LAST_IDX  = 6'(PAYLOAD_LEN - 1);
    localparam logic [6:0]       PAY_BASE  = 7'(8 + HDR_LEN);
    localparam logic [6:0]       PAY_END   = 7'(FRAME_LEN);

    state_e           state_q, state_d;
    logic [5:0]       wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             start_q, busy_q, in_ready_q;
    logic             ram_we_s;
    logic [7:0]       ram_wdata_s;
    logic             overflow_s;
    logic             xfer_s;
    logic             rd_is_pay_s, rd_is_pay_q;
    logic [7:0]       hdr_byte_s, hdr_q;
    logic [7:0]       ram_rdata_s;

    // Preamble, SFD and header bytes for a given frame address; zero elsewhere.
    function automatic logic [7:0] header_byte(input logic [6:0] a);
        int unsigned ai;
        logic [47:0] sh;
        logic [7:0]  b;
        ai = 32'(a);
        sh = 48'h0;
        if (ai < 32'd7) begin
            b = PREAMBLE;
        end else if (ai == 32'd7) begin
            b = SFD;
        end else if (ai < 32'd14) begin
            sh = DST_MAC >> (32'd8 * (32'd13 - ai));
            b  = sh[7:0];
        end else if (ai < 32'd20) begin
            sh = SRC_MAC >> (32'd8 * (32'd19 - ai));
            b  = sh[7:0];
        end else if (ai == 32'd20) begin
            b = ETHERTYPE[15:8];
        end else if (ai == 32'd21) begin
            b = ETHERTYPE[7:0];
        end else begin
            b = 8'h00;
        end
        return b;
    endfunction

    assign xfer_s = in_valid & in_ready_q;

    // Next-state, write-index, hold-counter and RAM write-port decode.
    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        hold_cnt_d  = hold_cnt_q;
        ram_we_s    = 1'b0;
        ram_wdata_s = in_data;
        overflow_s  = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (xfer_s) begin
                    ram_we_s = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        state_d = in_last ? ST_ARM : ST_DROP;
                    end else begin
                        wr_idx_d = wr_idx_q + 6'd1;
                        state_d  = in_last ? ST_PAD : ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DROP: begin
                if (xfer_s && in_last) begin
                    overflow_s = 1'b1;
                    state_d    = ST_ARM;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_PAD: begin
                ram_we_s    = 1'b1;
                ram_wdata_s = 8'h00;
                if (wr_idx_q == LAST_IDX) begin
                    state_d = ST_ARM;
                end else begin
                    wr_idx_d = wr_idx_q + 6'd1;
                end
            end
            ST_ARM: begin
                hold_cnt_d = HOLD_LOAD;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt_q == {CNT_W{1'b0}}) begin
                    state_d  = ST_FILL;
                    wr_idx_d = 6'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_FILL;
                wr_idx_d = 6'd0;
            end
        endcase
    end

    // State register plus output flags registered from the next state, so
    // start/busy/in_ready line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FILL;
            wr_idx_q   <= 6'd0;
            hold_cnt_q <= {CNT_W{1'b0}};
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            hold_cnt_q <= hold_cnt_d;
            start_q    <= (state_d == ST_ARM);
            busy_q     <= (state_d == ST_ARM) || (state_d == ST_HOLD);
            in_ready_q <= (state_d == ST_FILL) || (state_d == ST_DROP);
        end
    end

    assign rd_is_pay_s = (rd_addr >= PAY_BASE) && (rd_addr < PAY_END);
    assign hdr_byte_s  = header_byte(rd_addr);

    // Read-path select and constant-header byte, registered alongside the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_is_pay_q <= 1'b0;
            hdr_q       <= 8'h00;
        end else begin
            rd_is_pay_q <= rd_is_pay_s;
            hdr_q       <= hdr_byte_s;
        end
    end

    eth_payload_ram u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .waddr_i (wr_idx_q),
        .wdata_i (ram_wdata_s),
        .raddr_i (6'(rd_addr - PAY_BASE)),
        .rdata_o (ram_rdata_s)
    );

    assign rd_data  = rd_is_pay_q ? ram_rdata_s : hdr_q;
    assign in_ready = in_ready_q;
    assign start    = start_q;
    assign busy     = busy_q;
    // Overflow must mark the very cycle the final excess byte is taken.
    assign overflow = overflow_s;

endmodule

// File: tb/tb_eth_frame_builder.sv
// Self-checking bench for eth_frame_builder: a timeline model predicts the
// control outputs and frame image every cycle; directed tests pin literals.
module tb_eth_frame_builder;

    localparam int          HOLD = 1200;
    localparam logic [47:0] DST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC  = 48'h02_00_00_00_00_01;
    localparam logic [15:0] ET   = 16'h88B5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready, start, busy, overflow;
    logic [6:0] rd_addr = 7'd0;
    logic [7:0] rd_data;

    int errors = 0;
    int checks = 0;

    eth_frame_builder #(
        .DST_MAC(DST), .SRC_MAC(SRC), .ETHERTYPE(ET), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] img [0:45];
    int  t = 0;
    bit  synced = 0, active = 0, prev_rst = 0, prev_busy = 0;
    int  count = 0, c_cyc = 0, s_cyc = 0;
    logic [6:0] prev_addr = 7'd0;
    int  ovf_cnt = 0, start_cnt = 0;

    function automatic logic [7:0] model_byte(input int a);
        logic [47:0] sh;
        if (a < 7)       return 8'h55;
        else if (a == 7) return 8'hD5;
        else if (a < 14) begin sh = DST >> (8 * (13 - a)); return sh[7:0]; end
        else if (a < 20) begin sh = SRC >> (8 * (19 - a)); return sh[7:0]; end
        else if (a == 20) return ET[15:8];
        else if (a == 21) return ET[7:0];
        else if (a < 68) return img[a - 22];
        else return 8'h00;
    endfunction

    always @(posedge clk) t = t + 1;

    // Compare process: sampled on the falling edge, one timeline step per cycle.
    always @(negedge clk) begin
        bit exp_ready, exp_start, exp_busy, exp_ovf;
        int k;
        if (synced) begin
            if (active && t > s_cyc + HOLD) begin
                active = 0;
                count  = 0;
            end
            exp_ready = !(active && t > c_cyc);
            exp_start = active && (t == s_cyc);
            exp_busy  = active && (t >= s_cyc);
            exp_ovf   = exp_ready && in_valid && in_last && (count >= 46);
            chk("in_ready", in_ready, exp_ready);
            chk("start", start, exp_start);
            chk("busy", busy, exp_busy);
            chk("overflow", overflow, exp_ovf);
            if (prev_rst)
                chk("rd_data_reset", rd_data, 8'h00);
            else if (prev_addr < 7'd22 || prev_addr >= 7'd68 || prev_busy)
                chk("rd_data", rd_data, model_byte(int'(prev_addr)));
        end else begin
            exp_ready = 1'b0;
            exp_busy  = 1'b0;
        end
        if (overflow === 1'b1) ovf_cnt++;
        if (start === 1'b1) start_cnt++;
        prev_rst  = rst;
        prev_addr = rd_addr;
        prev_busy = synced && exp_busy && !rst;
        if (rst) begin
            active = 0;
            count  = 0;
            synced = 1;
        end else if (synced && exp_ready && in_valid) begin
            if (count < 46) img[count] = in_data;
            count++;
            if (in_last) begin
                k = (count > 46) ? 46 : count;
                for (int i = k; i < 46; i++) img[i] = 8'h00;
                c_cyc  = t;
                s_cyc  = t + (46 - k) + 1;
                active = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit last);
        int tries = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            tries++;
            if (tries > 3000) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (start) break;
            if (n > 200) begin
                chk("start_timeout", 32'd0, 32'd1);
                break;
            end
        end
        tick();
    endtask

    task automatic wait_idle;
        int n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 3000) begin
                chk("idle_timeout", 32'd0, 32'd1);
                break;
            end
        end
        tick();
    endtask

    task automatic read_chk(input logic [6:0] a, input logic [7:0] exp, input string name);
        rd_addr = a;
        tick();
        chk(name, rd_data, exp);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int n, low, bcnt, starts0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rd_data", rd_data, 8'h00);

        // One-byte payload, padded with 45 zeros.
        send(8'hAB, 1'b1);
        wait_start(n);
        chk("pad_latency", n, 46);
        read_chk(7'd22, 8'hAB, "r21_22");
        read_chk(7'd23, 8'h00, "r21_23");
        read_chk(7'd67, 8'h00, "r21_67");
        read_chk(7'd7,  8'hD5, "r21_sfd");
        read_chk(7'd20, 8'h88, "r21_et_hi");
        read_chk(7'd21, 8'hB5, "r21_et_lo");
        read_chk(7'd8,  8'hFF, "r21_dst");
        read_chk(7'd14, 8'h02, "r21_src_hi");
        read_chk(7'd19, 8'h01, "r21_src_lo");
        read_chk(7'd3,  8'h55, "r21_pre");
        wait_idle();

        // Exactly 46 bytes: no padding, no overflow.
        for (int i = 0; i < 46; i++) send(8'(i), i == 45);
        wait_start(n);
        chk("full_latency", n, 1);
        chk("full_no_ovf", ovf_cnt, 0);
        read_chk(7'd67, 8'h2D, "r22_67");
        read_chk(7'h44, 8'h00, "r22_44");
        read_chk(7'h7F, 8'h00, "r22_7f");
        read_chk(7'd22, 8'h00, "r22_22");
        wait_idle();

        // 50 bytes: last four dropped, one overflow pulse then start.
        for (int i = 0; i < 50; i++) send(8'(i), i == 49);
        wait_start(n);
        chk("drop_latency", n, 1);
        chk("drop_ovf_cnt", ovf_cnt, 1);
        read_chk(7'd67, 8'h2D, "r23_67");
        read_chk(7'd66, 8'h2C, "r23_66");
        wait_idle();

        // in_valid held through HOLD: measure the locked window.
        send(8'h10, 1'b0); send(8'h11, 1'b0); send(8'h12, 1'b1);
        wait_start(n);
        in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
        low = 0; bcnt = 1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            low++;
            if (busy) bcnt++;
            if (low > 3000) begin
                chk("hold_timeout", 32'd0, 32'd1);
                break;
            end
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("hold_ready_low", low, HOLD);
        chk("hold_busy_len", bcnt, HOLD + 1);
        wait_start(n);
        chk("after_hold_latency", n, 46);
        read_chk(7'd22, 8'h77, "r24_22");
        read_chk(7'd23, 8'h00, "r24_23");
        wait_idle();

        // Reset during HOLD abandons the frame.
        send(8'hE1, 1'b0); send(8'hE2, 1'b0); send(8'hE3, 1'b1);
        wait_start(n);
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        starts0 = start_cnt;
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_start", start, 1'b0);
        repeat (50) tick();
        chk("rst_no_start", start_cnt, starts0);
        send(8'h31, 1'b0); send(8'h32, 1'b0); send(8'h33, 1'b1);
        wait_start(n);
        chk("rst3_latency", n, 44);
        read_chk(7'd22, 8'h31, "r25_22");
        read_chk(7'd24, 8'h33, "r25_24");
        read_chk(7'd25, 8'h00, "r25_25");
        wait_idle();

        // in_valid toggling: only valid cycles advance the write index.
        for (int i = 0; i < 10; i++) begin
            send(8'hC0 + 8'(i), i == 9);
            tick();
        end
        wait_start(n);
        for (int a = 22; a < 68; a++) read_chk(7'(a), model_byte(a), "r26_image");
        read_chk(7'd22, 8'hC0, "r26_first");
        read_chk(7'd31, 8'hC9, "r26_last");
        read_chk(7'd32, 8'h00, "r26_pad");
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_frame_builder.md
ETH_FRAME_BUILDER -- requirements
Module: eth_frame_builder

Interface
REQ-001 SHALL have parameters, one per line:
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC placed at frame bytes 8..13, MSB first.
- SRC_MAC, 48'h02_00_00_00_00_01, source MAC at bytes 14..19, MSB first.
- ETHERTYPE, 16'h88B5, EtherType at bytes 20..21, MSB first.
- HOLD_CYCLES, 1200, cycles the buffer stays locked after start (covers 73 bytes x 16 clk of transmission).
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  payload byte valid.
- in_data  in  8  payload byte.
- in_last  in  1  marks final payload byte of a frame.
- in_ready  out  1  builder accepts the byte this cycle.
- start  out  1  one-cycle pulse telling the transmitter to send.
- rd_addr  in  7  transmitter read address.
- rd_data  out  8  frame byte at rd_addr, registered.
- busy  out  1  frame armed or being transmitted.
- overflow  out  1  one-cycle pulse when excess payload bytes are dropped.
REQ-003 SHALL use one clock; reset synchronous and active-high, as decided.

Function
REQ-004 SHALL present a 68-byte (0x00..0x43) frame image: bytes 0..6 = 0x55, byte 7 = 0xD5, 8..21 header per REQ-001, 22..67 = 46-byte payload RAM.
REQ-005 SHALL return rd_data = image[rd_addr] one cycle after rd_addr (registered, 1-cycle latency); rd_addr 0x44..0x7F SHALL return 0x00.
REQ-006 SHALL implement states FILL, DROP, PAD, ARM, HOLD.
REQ-007 FILL: in_ready=1; a byte transfers when in_valid & in_ready; written to payload[wr_idx], wr_idx increments (0..45).
REQ-008 FILL, transfer with in_last and wr_idx<45 -> PAD; transfer with wr_idx==45 and in_last -> ARM; transfer with wr_idx==45, no in_last -> DROP.
REQ-009 DROP: in_ready=1, bytes discarded; on transfer with in_last -> ARM and overflow pulses that cycle.
REQ-010 PAD: in_ready=0; writes 0x00 to payload[wr_idx] one byte per cycle through index 45, then -> ARM.
REQ-011 ARM: start=1 for exactly one cycle, hold counter loaded with HOLD_CYCLES-1, -> HOLD.
REQ-012 HOLD: in_ready=0, payload RAM not written; counter decrements each cycle; at 0 -> FILL with wr_idx=0.
REQ-013 busy SHALL be 1 in ARM and HOLD, 0 otherwise.
REQ-014 in_last on a payload of 1 byte SHALL produce 45 pad bytes; an empty frame is impossible (in_last qualifies a byte).
REQ-015 rd_data SHALL be valid in every state; reads during FILL/PAD return the partially written image.
REQ-016 Payload index SHALL be 6 bits; hold counter 11 bits minimum, sized from HOLD_CYCLES.

Reset
REQ-017 rst SHALL force state FILL, wr_idx=0, hold counter 0, start=0, overflow=0, busy=0, rd_data=0x00; in_ready=1 the cycle after rst deasserts.
REQ-018 rst mid-HOLD or mid-PAD SHALL abandon the frame without a start pulse; payload RAM contents need not be cleared.

Structure
REQ-019 Shared package SHALL hold the state enumeration, PREAMBLE=0x55, SFD=0xD5, FRAME_LEN=68, PAYLOAD_LEN=46, HDR_LEN=14.
REQ-020 One sub-module, eth_payload_ram (46x8, one write port, one registered read port), SHALL hold the payload; header/preamble muxing stays in the top.

Verification
REQ-021 1-byte payload 0xAB, in_last -> PAD 45 cycles, start pulse; rd_addr 22 -> 0xAB, 23..67 -> 0x00, 7 -> 0xD5, 20 -> 0x88, 21 -> 0xB5.
REQ-022 46 bytes 0..45, last on byte 45 -> no PAD, start next cycle, overflow=0; rd_addr 67 -> 0x2D, 0x44 -> 0x00.
REQ-023 50 bytes, last on byte 49 -> bytes 46..49 dropped, overflow pulses once with start following, rd_addr 67 = byte 45.
REQ-024 in_valid held during HOLD -> in_ready=0 for exactly HOLD_CYCLES cycles after start; busy=1 for HOLD_CYCLES+1 cycles; next frame accepted afterwards.
REQ-025 rst asserted at HOLD cycle 100 -> busy=0, no start, in_ready=1 next cycle; new 3-byte frame builds and starts normally.
REQ-026 in_valid toggling every other cycle -> only valid cycles advance wr_idx; image matches scoreboard byte-for-byte.
